// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge bus between the MEM-stage sequencer and a word-wide data memory.
interface mem_access_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer for the RV32 pipeline: word/byte loads, word stores and
// read-modify-write byte stores over a variable-latency req/ack data memory.
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  StSrcM,
    input  logic                  LdSrcM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    mem_access_ctrl_if.master     mem,
    output logic                  StallM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  ReadValidM,
    output logic                  MemErrM
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_RMW_WR,
        S_STORE,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_read_valid;
    logic                  r_mem_err;
    logic [CW-1:0]         r_cnt;
    logic [1:0]            r_lane;
    logic [7:0]            r_wbyte;
    logic                  r_byte_ld;

    logic                  w_acc;
    logic                  w_busy;
    logic                  w_timeout;
    logic [7:0]            w_rd_byte;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_acc     = MemWriteM | (ResultSrcM == 2'b01);
    assign w_busy    = (r_state == S_LOAD) | (r_state == S_RMW_RD) |
                       (r_state == S_RMW_WR) | (r_state == S_STORE);
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
    assign w_rd_byte = mem.mem_rdata[{r_lane, 3'b000} +: 8];

    // NOTE: combinational blocks assign a full default first so no latch is inferred.
    always_comb begin
        w_merged                         = mem.mem_rdata;
        w_merged[{r_lane, 3'b000} +: 8]  = r_wbyte;
    end

    // Stall is asserted in the same cycle the access is first seen so EX/MEM holds it.
    assign StallM = ((r_state == S_IDLE) & w_acc) | w_busy;

    // NOTE: sequential state uses non-blocking assignments only; every register,
    // including the data-path ones, is cleared by reset so a mid-access reset leaves no stale bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_mem_err    <= 1'b0;
            r_cnt        <= '0;
            r_lane       <= 2'b00;
            r_wbyte      <= 8'h00;
            r_byte_ld    <= 1'b0;
        end else begin
            r_read_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                        r_cnt      <= '0;
                        r_lane     <= ALUResultM[1:0];
                        r_wbyte    <= WriteDataM[7:0];
                        r_byte_ld  <= LdSrcM;
                        if (MemWriteM) begin
                            if (StSrcM) begin
                                r_mem_we <= 1'b0;
                                r_state  <= S_RMW_RD;
                            end else begin
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= WriteDataM;
                                r_state     <= S_STORE;
                            end
                        end else begin
                            r_mem_we <= 1'b0;
                            r_state  <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (mem.mem_ack) begin
                        r_read_data  <= r_byte_ld ? {{(DATA_WIDTH-8){1'b0}}, w_rd_byte}
                                                  : mem.mem_rdata;
                        r_read_valid <= 1'b1;
                        r_mem_req    <= 1'b0;
                        r_state      <= S_DONE;
                    end else if (w_timeout) begin
                        r_read_data  <= '0;
                        r_read_valid <= 1'b1;
                        r_mem_err    <= 1'b1;
                        r_mem_req    <= 1'b0;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RMW_RD: begin
                    if (mem.mem_ack) begin
                        r_mem_wdata <= w_merged;
                        r_mem_we    <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_RMW_WR;
                    end else if (w_timeout) begin
                        r_mem_err <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RMW_WR, S_STORE: begin
                    if (mem.mem_ack || w_timeout) begin
                        r_mem_err <= r_mem_err | ~mem.mem_ack;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign ReadDataM     = r_read_data;
    assign ReadValidM    = r_read_valid;
    assign MemErrM       = r_mem_err;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a req/ack memory responder plus a
// scoreboard monitor that checks every completed bus transaction and load result.
module tb_mem_access_ctrl;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        string       name;
        logic        mw;
        logic [1:0]  rs;
        logic        byte_op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          lat;
        int          exp_stall;
        logic [31:0] exp_addr;
        logic [31:0] exp_wword;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic        StSrcM;
    logic        LdSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        ReadValidM;
    logic        MemErrM;

    mem_access_ctrl_if #(.DATA_WIDTH(32)) mem ();

    mem_access_ctrl #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .StSrcM     (StSrcM),
        .LdSrcM     (LdSrcM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .mem        (mem.master),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .ReadValidM (ReadValidM),
        .MemErrM    (MemErrM)
    );

    int          n_vec = 0;
    int          n_err = 0;
    bus_t        exp_bus[$];
    logic [31:0] exp_rd[$];
    int          ack_lat = 0;
    logic [31:0] rd_word = 32'h0;
    logic        stray = 1'b0;
    int          resp_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks in the ack_lat-th cycle of each transaction (0 = never).
    always @(posedge clk) begin
        #1;
        if (mem.mem_ack || !mem.mem_req) resp_cnt = 0;
        mem.mem_ack = 1'b0;
        if (mem.mem_req) begin
            resp_cnt++;
            if (ack_lat != 0 && resp_cnt == ack_lat) begin
                mem.mem_ack   = 1'b1;
                mem.mem_rdata = rd_word;
            end
        end
        if (stray) mem.mem_ack = 1'b1;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        bus_t        b;
        logic [31:0] r;
        if (mem.mem_req && mem.mem_ack) begin
            if (exp_bus.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL bus_unexpected: addr %h we %b", mem.mem_addr, mem.mem_we);
            end else begin
                b = exp_bus.pop_front();
                check("bus_addr", mem.mem_addr, b.addr);
                check("bus_we", {31'b0, mem.mem_we}, {31'b0, b.we});
                if (b.we) check("bus_wdata", mem.mem_wdata, b.wdata);
            end
        end
        if (ReadValidM) begin
            if (exp_rd.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL read_unexpected: ReadDataM %h", ReadDataM);
            end else begin
                r = exp_rd.pop_front();
                check("read_data", ReadDataM, r);
            end
        end
    end

    task automatic clear_inputs();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        StSrcM     = 1'b0;
        LdSrcM     = 1'b0;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
    endtask

    // Issues one instruction, holds it while stalled, and releases it after DONE.
    task automatic do_access(input vec_t v);
        int stall_n = 0;
        int req_n   = 0;
        if (v.mw) begin
            if (v.byte_op) exp_bus.push_back('{v.exp_addr, 1'b0, 32'h0});
            exp_bus.push_back('{v.exp_addr, 1'b1, v.exp_wword});
        end else begin
            if (v.lat != 0) exp_bus.push_back('{v.exp_addr, 1'b0, 32'h0});
            exp_rd.push_back(v.exp_rdata);
        end
        rd_word    = v.rword;
        ack_lat    = v.lat;
        MemWriteM  = v.mw;
        ResultSrcM = v.rs;
        StSrcM     = v.byte_op;
        LdSrcM     = v.byte_op;
        ALUResultM = v.addr;
        WriteDataM = v.wdata;
        forever begin
            @(negedge clk);
            if (!StallM) break;
            stall_n++;
            if (mem.mem_req) req_n++;
            if (stall_n > 50) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_stall_bound: StallM still high after %0d cycles", v.name, stall_n);
                break;
            end
        end
        check({v.name, "_stall"}, stall_n, v.exp_stall);
        check({v.name, "_req_cycles"}, req_n, v.exp_stall - 1);
        check({v.name, "_done_req"}, {31'b0, mem.mem_req}, 32'h0);
        check({v.name, "_done_we"}, {31'b0, mem.mem_we}, 32'h0);
        check({v.name, "_done_valid"}, {31'b0, ReadValidM}, {31'b0, ~v.mw});
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    vec_t vecs[7];
    vec_t v_timeout;
    vec_t v_after;

    initial begin
        vecs[0] = '{"lw_wait3",  1'b0, 2'b01, 1'b0, 32'h104, 32'h0,        32'hDEADBEEF, 3, 4, 32'h104, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{"lbu_lane3", 1'b0, 2'b01, 1'b1, 32'h207, 32'h0,        32'hA1B2C3D4, 1, 2, 32'h204, 32'h0,        32'h000000A1};
        vecs[2] = '{"sb_lane2",  1'b1, 2'b00, 1'b1, 32'h302, 32'h55,       32'h11223344, 1, 3, 32'h300, 32'h11553344, 32'h0};
        vecs[3] = '{"sw_prio",   1'b1, 2'b01, 1'b0, 32'h40C, 32'hCAFEF00D, 32'h0,        2, 3, 32'h40C, 32'hCAFEF00D, 32'h0};
        vecs[4] = '{"lw_b2b",    1'b0, 2'b01, 1'b0, 32'h40C, 32'h0,        32'h13579BDF, 1, 2, 32'h40C, 32'h0,        32'h13579BDF};
        vecs[5] = '{"sb_lane0",  1'b1, 2'b00, 1'b1, 32'h400, 32'h123456AB, 32'hFFFFFFFF, 2, 5, 32'h400, 32'hFFFFFFAB, 32'h0};
        vecs[6] = '{"lbu_lane1", 1'b0, 2'b01, 1'b1, 32'h401, 32'h0,        32'h00008000, 1, 2, 32'h400, 32'h0,        32'h00000080};
        v_timeout = '{"lw_timeout", 1'b0, 2'b01, 1'b0, 32'h500, 32'h0, 32'h0,        0, 5, 32'h500, 32'h0, 32'h0};
        v_after   = '{"lw_post_rst", 1'b0, 2'b01, 1'b0, 32'h104, 32'h0, 32'h0BADF00D, 1, 2, 32'h104, 32'h0, 32'h0BADF00D};

        mem.mem_ack   = 1'b0;
        mem.mem_rdata = 32'h0;
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, mem.mem_req}, 32'h0);
        check("rst_stall", {31'b0, StallM}, 32'h0);
        check("rst_rdata", ReadDataM, 32'h0);
        check("rst_valid", {31'b0, ReadValidM}, 32'h0);
        check("rst_err", {31'b0, MemErrM}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) do_access(vecs[i]);
        check("err_before_timeout", {31'b0, MemErrM}, 32'h0);

        do_access(v_timeout);
        check("timeout_err", {31'b0, MemErrM}, 32'h1);
        check("timeout_rdata", ReadDataM, 32'h0);
        repeat (3) @(negedge clk);
        check("timeout_err_sticky", {31'b0, MemErrM}, 32'h1);
        check("timeout_stall_released", {31'b0, StallM}, 32'h0);

        // Byte store stalled in its read phase, then reset mid-transaction.
        @(posedge clk);
        #1;
        ack_lat    = 0;
        MemWriteM  = 1'b1;
        StSrcM     = 1'b1;
        ALUResultM = 32'h602;
        WriteDataM = 32'h77;
        @(negedge clk);
        check("rmw_issue_stall", {31'b0, StallM}, 32'h1);
        @(negedge clk);
        check("rmw_rd_req", {31'b0, mem.mem_req}, 32'h1);
        check("rmw_rd_addr", mem.mem_addr, 32'h600);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        check("midrst_req", {31'b0, mem.mem_req}, 32'h0);
        check("midrst_we", {31'b0, mem.mem_we}, 32'h0);
        check("midrst_addr", mem.mem_addr, 32'h0);
        check("midrst_err", {31'b0, MemErrM}, 32'h0);
        check("midrst_rdata", ReadDataM, 32'h0);
        check("midrst_stall", {31'b0, StallM}, 32'h0);

        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        check("stray_ack_seen", {31'b0, mem.mem_ack}, 32'h1);
        check("stray_req", {31'b0, mem.mem_req}, 32'h0);
        check("stray_stall", {31'b0, StallM}, 32'h0);
        @(negedge clk);
        check("stray_after_req", {31'b0, mem.mem_req}, 32'h0);
        check("stray_after_valid", {31'b0, ReadValidM}, 32'h0);
        check("stray_after_stall", {31'b0, StallM}, 32'h0);
        @(posedge clk);
        #1;
        do_access(v_after);

        repeat (3) @(negedge clk);
        check("bus_queue_drained", exp_bus.size(), 32'h0);
        check("read_queue_drained", exp_rd.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
